// File: rtl/alu_cnt_dec_unit_if.sv
// rtl/alu_cnt_dec_unit_if.sv - port bundle for the ALU / down-counter / decoder utility block
interface alu_cnt_dec_unit_if;
    logic [2:0] alu_fnselec;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_res;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_overflow;
    logic       counter_en;
    logic [2:0] dec_counter_out;
    logic [2:0] x;
    logic       en;
    logic [7:0] y_dec;

    // Driver side: supplies operands, selects and enables.
    modport master (
        output alu_fnselec, alu_a, alu_b, counter_en, x, en,
        input  alu_res, alu_zero, alu_carry, alu_overflow, dec_counter_out, y_dec
    );

    // Block side: consumes operands, produces results.
    modport slave (
        input  alu_fnselec, alu_a, alu_b, counter_en, x, en,
        output alu_res, alu_zero, alu_carry, alu_overflow, dec_counter_out, y_dec
    );
endinterface

// File: rtl/alu_cnt_dec_unit.sv
// rtl/alu_cnt_dec_unit.sv - 4-bit ALU with flags, 3-bit down-counter, 3-to-8 decoder (option: ALU_OUT_REG_EN)
module alu_cnt_dec_unit (
    input  logic              clk,
    input  logic              rst,
    alu_cnt_dec_unit_if.slave bus
);

    logic [4:0] add_full;
    logic [4:0] sub_full;
    logic       add_ovf;
    logic       sub_ovf;
    logic       signed_lt;
    logic [3:0] res_c;
    logic       carry_c;
    logic       ovf_c;
    logic       zero_c;
    logic [2:0] count_q;
    logic [7:0] y_c;

    // Add and subtract share the same 5-bit form so bit 4 is the carry-out.
    assign add_full  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign sub_full  = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
    assign add_ovf   = (bus.alu_a[3] == bus.alu_b[3]) && (add_full[3] != bus.alu_a[3]);
    assign sub_ovf   = (bus.alu_a[3] != bus.alu_b[3]) && (sub_full[3] != bus.alu_a[3]);
    assign signed_lt = sub_full[3] ^ sub_ovf;

    // Operation select; flags derive from the same result so they never disagree.
    always_comb begin
        res_c   = 4'd0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (bus.alu_fnselec)
            3'b000: begin
                res_c   = add_full[3:0];
                carry_c = add_full[4];
                ovf_c   = add_ovf;
            end
            3'b001: begin
                res_c   = sub_full[3:0];
                carry_c = sub_full[4];
                ovf_c   = sub_ovf;
            end
            3'b010:  res_c = ~bus.alu_a;
            3'b011:  res_c = bus.alu_a & bus.alu_b;
            3'b100:  res_c = bus.alu_a | bus.alu_b;
            3'b101:  res_c = bus.alu_a ^ bus.alu_b;
            3'b110:  res_c = {3'b000, signed_lt};
            default: res_c = {3'b000, (bus.alu_a == bus.alu_b)};
        endcase
        zero_c = (res_c == 4'd0);
    end

`ifdef ALU_OUT_REG_EN
    logic [3:0] res_q;
    logic       zero_q;
    logic       carry_q;
    logic       ovf_q;

    // One-cycle registered ALU outputs; all clear (zero flag included) during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= 4'd0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            res_q   <= res_c;
            zero_q  <= zero_c;
            carry_q <= carry_c;
            ovf_q   <= ovf_c;
        end
    end

    assign bus.alu_res      = res_q;
    assign bus.alu_zero     = zero_q;
    assign bus.alu_carry    = carry_q;
    assign bus.alu_overflow = ovf_q;
`else
    assign bus.alu_res      = res_c;
    assign bus.alu_zero     = zero_c;
    assign bus.alu_carry    = carry_c;
    assign bus.alu_overflow = ovf_c;
`endif

    // Down-counter: reset loads 7, enabled edges decrement, 0 wraps naturally to 7.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 3'd7;
        end else if (bus.counter_en) begin
            count_q <= count_q - 3'd1;
        end
    end

    assign bus.dec_counter_out = count_q;

    // One-hot decode of x, forced low when disabled.
    always_comb begin
        y_c = 8'h00;
        if (bus.en) begin
            y_c = 8'd1 << bus.x;
        end
    end

    assign bus.y_dec = y_c;

endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
// tb/tb_alu_cnt_dec_unit.sv - directed self-checking bench for alu_cnt_dec_unit
module tb_alu_cnt_dec_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_cnt_dec_unit_if bus ();

    alu_cnt_dec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        bus.counter_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.dec_counter_out !== 3'd7) begin
            errors++;
            $display("FAIL reset_async got %0d expected 7", bus.dec_counter_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.dec_counter_out !== 3'd7) begin
            errors++;
            $display("FAIL reset_hold got %0d expected 7", bus.dec_counter_out);
        end
        bus.counter_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        // {sel, a, b, res, zero, carry, ovf}
        logic [17:0] vec [0:13];
        logic [6:0]  got;
        logic [6:0]  exp;
        vec[0]  = {3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1};
        vec[1]  = {3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0};
        vec[2]  = {3'b001, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0};
        vec[3]  = {3'b001, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b1, 1'b0};
        vec[4]  = {3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1};
        vec[5]  = {3'b110, 4'b1000, 4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0};
        vec[6]  = {3'b110, 4'b0111, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0};
        vec[7]  = {3'b111, 4'b0101, 4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0};
        vec[8]  = {3'b111, 4'b0101, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0};
        vec[9]  = {3'b010, 4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0};
        vec[10] = {3'b011, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
        vec[11] = {3'b011, 4'b0101, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0};
        vec[12] = {3'b100, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0};
        vec[13] = {3'b101, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            bus.alu_fnselec = vec[i][17:15];
            bus.alu_a       = vec[i][14:11];
            bus.alu_b       = vec[i][10:7];
            #1;
            got = {bus.alu_res, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
            exp = vec[i][6:0];
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL alu_vec%0d sel=%b a=%b b=%b got res/z/c/v=%b expected %b",
                         i, vec[i][17:15], vec[i][14:11], vec[i][10:7], got, exp);
            end
        end
    endtask

    task automatic test_counter();
        logic [2:0] exp_seq [0:7];
        exp_seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        @(negedge clk);
        bus.counter_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.dec_counter_out !== exp_seq[i]) begin
                errors++;
                $display("FAIL count_step%0d got %0d expected %0d", i, bus.dec_counter_out, exp_seq[i]);
            end
        end
        @(negedge clk);
        bus.counter_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.dec_counter_out !== 3'd7) begin
                errors++;
                $display("FAIL count_hold%0d got %0d expected 7", i, bus.dec_counter_out);
            end
        end
    endtask

    task automatic test_counter_reset_mid();
        @(negedge clk);
        bus.counter_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.dec_counter_out !== 3'd5) begin
            errors++;
            $display("FAIL mid_pre got %0d expected 5", bus.dec_counter_out);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.dec_counter_out !== 3'd7) begin
            errors++;
            $display("FAIL mid_reset got %0d expected 7", bus.dec_counter_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.dec_counter_out !== 3'd6) begin
            errors++;
            $display("FAIL first_after_reset got %0d expected 6", bus.dec_counter_out);
        end
        @(negedge clk);
        bus.counter_en = 1'b0;
    endtask

    task automatic test_decoder();
        logic [7:0] exp;
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.x = i[2:0];
            #1;
            exp = 8'd1 << i;
            checks++;
            if (bus.y_dec !== exp) begin
                errors++;
                $display("FAIL dec_en x=%0d got %b expected %b", i, bus.y_dec, exp);
            end
        end
        bus.x = 3'd5;
        #1;
        checks++;
        if (bus.y_dec !== 8'b0010_0000) begin
            errors++;
            $display("FAIL dec_x5 got %b expected 00100000", bus.y_dec);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.x = i[2:0];
            #1;
            checks++;
            if (bus.y_dec !== 8'h00) begin
                errors++;
                $display("FAIL dec_dis x=%0d got %b expected 00000000", i, bus.y_dec);
            end
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b0;
        bus.alu_fnselec = 3'b000;
        bus.alu_a       = 4'd0;
        bus.alu_b       = 4'd0;
        bus.counter_en  = 1'b0;
        bus.x           = 3'd0;
        bus.en          = 1'b0;
        test_reset();
        test_alu();
        test_counter();
        test_counter_reset_mid();
        test_decoder();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
